rsign_layer7_ctrl: RTL
======================

# rsign_layer7_ctrl

Sequencer for the layer-7 RSign threshold stage and the eight compute macros behind it. It loads the per-channel RSign thresholds in beats, then drives the RSign stage's calculate mode, data enable and half-select. For every input window it runs the macros twice: once on channels 0–127 and once on channels 128–255. It sits between the layer-7 window buffer, the parameter loader, the RSign stage and the macro array.

## Interface
Parameters:
- FM_DEPTH, 256, number of channels; must be a multiple of 2·PARA_PER_BEAT
- PARA_PER_BEAT, 16, thresholds delivered per load beat
- WIN_COUNT, 49, windows per layer pass
- WDOG_CYCLES, 1023, macro watchdog limit; used only with RSIGN_CTRL_WDOG_EN

Ports (width uses `PARA_WIDTH from defines.v):
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a layer pass
- para_valid  in  1  parameter beat valid
- para_ready  out  1  controller accepts a parameter beat
- para_beat  in  PARA_PER_BEAT·`PARA_WIDTH  thresholds; element e sits at bits [e·W +: W]
- para  out  signed `PARA_WIDTH × FM_DEPTH  registered threshold bank, fed to the RSign stage
- mode  out  1  0 = reload, 1 = calculate
- win_valid  in  1  upstream window present
- win_ready  out  1  window accepted when high together with win_valid
- data_e  out  1  RSign data enable
- chs_macro  out  2  bit0 is the half select (0 = channels 0–127, 1 = channels 128–255); bit1 is held at 0 (reserved)
- macro_start  out  1  one-cycle macro start pulse
- macro_done  in  1  one-cycle completion pulse from the macros
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at the end of a pass
- err  out  1  sticky watchdog error flag

## Operation
- States: IDLE, LOAD, WAIT_WIN, HALF0, HALF1, FIN.
- IDLE:
  - start → LOAD; clear the beat counter and the window counter.
  - start while busy is ignored.
- LOAD:
  - mode=0, para_ready=1.
  - Each beat with para_valid writes para[k·PARA_PER_BEAT + e] ← element e, where k is the beat counter.
  - After beat FM_DEPTH/PARA_PER_BEAT−1 (beat 15 by default) → WAIT_WIN.
  - para_valid outside LOAD is ignored and the bank is left unchanged.
- WAIT_WIN:
  - mode=1, win_ready=1.
  - On win_valid: data_e=1 for exactly that cycle (combinational from the handshake), then → HALF0.
- HALF0:
  - chs_macro=2'b00.
  - macro_start is pulsed in the first cycle of the state.
  - macro_done is sampled only from the cycle after macro_start. When it arrives → HALF1.
- HALF1:
  - chs_macro=2'b01; macro_start is pulsed in the first cycle of the state.
  - On macro_done: if window counter = WIN_COUNT−1 → FIN; otherwise increment the counter and → WAIT_WIN.
- FIN: done=1 for one cycle, then → IDLE. mode stays 1 until the next start.
- chs_macro[0] holds its value outside the HALF states; it returns to 0 on entry to HALF0.
- macro_done outside HALF0/HALF1, or in the same cycle as macro_start, is ignored.
- Window counter: $clog2(WIN_COUNT) bits. It never wraps within a pass.

## Timing
- Reset values:
  - mode, data_e, chs_macro, macro_start, para_ready, win_ready, busy, done and err are all 0.
  - Every para entry is 0.
  - State is IDLE.
- Reset asserted mid-pass returns everything to the reset values immediately (asynchronous). No done pulse is issued.
- start → para_ready high on the next cycle.
- Last parameter beat accepted at cycle T → mode=1 and win_ready=1 at T+1.
- Window accepted at cycle T (data_e high) → the RSign output is registered at edge T+1 → macro_start with chs_macro=00 in cycle T+1.
- macro_done in cycle D (HALF0) → macro_start with chs_macro=01 in cycle D+1.
- macro_done in cycle D (HALF1):
  - not the last window → win_ready in cycle D+1;
  - last window → done in cycle D+1.
- Minimum cost per window, with macro_done arriving one cycle after each start: 5 cycles.

## Configuration
- RSIGN_CTRL_WDOG_EN defined:
  - A counter runs in HALF0 and HALF1 and restarts at each macro_start.
  - If it reaches WDOG_CYCLES without macro_done: err←1 (sticky until reset), the FSM goes to IDLE and no done pulse is issued.
- RSIGN_CTRL_WDOG_EN undefined:
  - No counter is built, err is tied to 0, and the HALF states wait indefinitely.

## Test plan
- Reset, then start with 16 beats whose beat k holds values k·16+e: para[37]=37, para[255]=255, mode rises 1 cycle after the last beat, and no beat is accepted twice.
- WIN_COUNT=3, win_valid held high, macro_done returned 1 cycle after every start: exactly 3 data_e pulses, chs_macro sequence 0,1 per window, done at cycle D+1 after the 6th macro_done, and 6 macro_start pulses in total.
- Stray pulses: macro_done during WAIT_WIN and para_valid during HALF0 produce no state change and no change to para; a second start while busy is ignored.
- Assert rst_n low during HALF1 of window 1: all outputs return to 0 and para is cleared; a fresh start then runs a full pass normally.
- With RSIGN_CTRL_WDOG_EN and WDOG_CYCLES=20, withhold macro_done: err=1 and busy=0 after 20 cycles, err stays 1 across a new start, and done never pulses. Without the macro defined, err stays 0 and the FSM stays in HALF0.

Source files
------------

// File: rtl/rsign_layer7_ctrl.sv
// rsign_layer7_ctrl
//   Sequencer for the layer-7 RSign threshold stage and the eight compute
//   macros behind it. One pass works in four steps:
//     1. Load the per-channel thresholds in beats of PARA_PER_BEAT.
//     2. Switch the RSign stage to calculate mode.
//     3. For every input window, run the macros on channels 0-127.
//     4. Run them again on channels 128-255.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle pulse that begins a layer pass (ignored while busy)
//   para_valid/ready     threshold beat handshake; para_beat element e at [e*W +: W]
//   para                 registered threshold bank (FM_DEPTH signed entries)
//   mode                 0 = reload, 1 = calculate (held at 1 after a pass)
//   win_valid/ready      window handshake; data_e pulses on the accepting cycle
//   chs_macro            bit0 = half select, bit1 reserved (0)
//   macro_start/done     macro start pulse / completion pulse
//   busy, done, err      not idle / end-of-pass pulse / sticky watchdog error
//
// Optional build macro: RSIGN_CTRL_WDOG_EN adds a macro watchdog of
// WDOG_CYCLES cycles. Without it, err is tied low and the HALF states wait forever.

`ifndef PARA_WIDTH
`define PARA_WIDTH 16
`endif

module rsign_layer7_ctrl #(
    parameter int FM_DEPTH      = 256,
    parameter int PARA_PER_BEAT = 16,
    parameter int WIN_COUNT     = 49,
    parameter int WDOG_CYCLES   = 1023
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  para_valid,
    output logic                                  para_ready,
    input  logic [PARA_PER_BEAT*`PARA_WIDTH-1:0]  para_beat,
    output logic signed [`PARA_WIDTH-1:0]         para [FM_DEPTH],
    output logic                                  mode,
    input  logic                                  win_valid,
    output logic                                  win_ready,
    output logic                                  data_e,
    output logic [1:0]                            chs_macro,
    output logic                                  macro_start,
    input  logic                                  macro_done,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
);

    localparam int BEATS  = FM_DEPTH / PARA_PER_BEAT;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WIN_W  = (WIN_COUNT > 1) ? $clog2(WIN_COUNT) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [WIN_W-1:0]  LAST_WIN  = WIN_W'(WIN_COUNT - 1);

    if ((FM_DEPTH % (2 * PARA_PER_BEAT)) != 0 || WIN_COUNT < 1 || WDOG_CYCLES < 1) begin : g_param_check
        $error("rsign_layer7_ctrl: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_WIN,
        S_HALF0,
        S_HALF1,
        S_FIN
    } state_e;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic              mode_q, mode_d;
    logic              half_q, half_d;
    logic              mstart_q, mstart_d;
    logic              beat_we;
    logic              in_half;
    logic              done_ok;
    logic              wdog_trip;

    assign in_half = (state_q == S_HALF0) || (state_q == S_HALF1);
    // A completion in the same cycle as the start pulse is stale; ignore it.
    assign done_ok = macro_done && !mstart_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            win_q    <= '0;
            mode_q   <= 1'b0;
            half_q   <= 1'b0;
            mstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            win_q    <= win_d;
            mode_q   <= mode_d;
            half_q   <= half_d;
            mstart_q <= mstart_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        win_d      = win_q;
        mode_d     = mode_q;
        half_d     = half_q;
        mstart_d   = 1'b0;
        beat_we    = 1'b0;
        para_ready = 1'b0;
        win_ready  = 1'b0;
        data_e     = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    beat_d  = '0;
                    win_d   = '0;
                    mode_d  = 1'b0;
                end
            end
            S_LOAD: begin
                para_ready = 1'b1;
                if (para_valid) begin
                    beat_we = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_WAIT_WIN;
                        mode_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_WAIT_WIN: begin
                win_ready = 1'b1;
                if (win_valid) begin
                    data_e   = 1'b1;
                    state_d  = S_HALF0;
                    half_d   = 1'b0;
                    mstart_d = 1'b1;
                end
            end
            S_HALF0: begin
                if (done_ok) begin
                    state_d  = S_HALF1;
                    half_d   = 1'b1;
                    mstart_d = 1'b1;
                end else if (wdog_trip) begin
                    state_d = S_IDLE;
                end
            end
            S_HALF1: begin
                if (done_ok) begin
                    if (win_q == LAST_WIN) begin
                        state_d = S_FIN;
                    end else begin
                        win_d   = win_q + 1'b1;
                        state_d = S_WAIT_WIN;
                    end
                end else if (wdog_trip) begin
                    state_d = S_IDLE;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Threshold bank: each entry only listens to the beat index it belongs to,
    // so no run-time indexed write is needed.
    for (genvar gi = 0; gi < FM_DEPTH; gi++) begin : g_bank
        localparam int BEAT_IDX = gi / PARA_PER_BEAT;
        localparam int ELEM_IDX = gi % PARA_PER_BEAT;
        logic signed [`PARA_WIDTH-1:0] entry_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_q <= '0;
            end else if (beat_we && (beat_q == BEAT_W'(BEAT_IDX))) begin
                entry_q <= $signed(para_beat[ELEM_IDX*`PARA_WIDTH +: `PARA_WIDTH]);
            end
        end
        assign para[gi] = entry_q;
    end

`ifdef RSIGN_CTRL_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_q;
    logic              err_q;

    // Counter is 0 in the macro_start cycle and trips WDOG_CYCLES cycles later.
    assign wdog_trip = in_half && !done_ok && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (mstart_d) begin
                wdog_q <= '0;
            end else if (in_half) begin
                wdog_q <= wdog_q + 1'b1;
            end
            if (wdog_trip) begin
                err_q <= 1'b1;
            end
        end
    end
    assign err = err_q;
`else
    assign wdog_trip = 1'b0;
    assign err       = 1'b0;
`endif

    assign mode        = mode_q;
    assign macro_start = mstart_q;
    assign chs_macro   = {1'b0, half_q};
    assign busy        = (state_q != S_IDLE);

endmodule
